// File: rtl/switch_egress_collector.sv
// switch_egress_collector
//
// Collects words from the four output ports of a switch into per-port FIFOs
// and serialises them onto a single downstream valid/ready stream. A
// round-robin arbiter picks which port feeds the output register.
//
// Ports:
//   clk         single clock, all state on posedge
//   reset       asynchronous, active-low; 0 clears all state
//   sw_valid    per-port valid from the switch (bit p = port p)
//   sw_data     per-port data byte, port p at [p*8+:8]
//   sw_addr     per-port address byte, port p at [p*8+:8]
//   pkt_ready   downstream consumer ready
//   pkt_valid   output word valid
//   pkt_data    output data byte
//   pkt_addr    output address byte
//   pkt_port    switch port the output word came from
//   fifo_full   bit p high while FIFO p holds DEPTH entries
//   drop_count  per-port saturating drop counter, port p at [p*8+:8]
//
// Handshake: a word transfers on any posedge where pkt_valid and pkt_ready
// are both 1. Once pkt_valid is raised, pkt_valid/pkt_data/pkt_addr/pkt_port
// stay stable until that transfer happens; pkt_ready never alters the
// outputs while pkt_valid is 0.
//
// All pkt_* outputs come straight from registers, so there is no
// combinational path from the switch inputs to the output stream.

module switch_egress_collector #(
    parameter int NPORTS = 4,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NPORTS-1:0]     sw_valid,
    input  logic [NPORTS*8-1:0]   sw_data,
    input  logic [NPORTS*8-1:0]   sw_addr,
    input  logic                  pkt_ready,
    output logic                  pkt_valid,
    output logic [7:0]            pkt_data,
    output logic [7:0]            pkt_addr,
    output logic [1:0]            pkt_port,
    output logic [NPORTS-1:0]     fifo_full,
    output logic [NPORTS*8-1:0]   drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Output stage state; kept as a named signal so checkers can bind to it.
    state_t        state;
    logic [1:0]    last_grant;

    // Per-port FIFO storage: each entry is {addr, data}.
    logic [15:0]   mem      [NPORTS][DEPTH];
    logic [AW-1:0] wr_ptr   [NPORTS];
    logic [AW-1:0] rd_ptr   [NPORTS];
    logic [CW-1:0] count    [NPORTS];
    logic [7:0]    drop_cnt [NPORTS];

    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] nonempty;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] accept;
    logic [NPORTS-1:0] drop;

    logic          grant_found;
    logic [1:0]    grant_idx;
    logic [1:0]    cand;
    logic          load;
    logic [15:0]   head;

    // Only a clean 1 qualifies a push; 0/X/Z are all treated as idle, and
    // nothing is captured while reset is held low.
    always_comb begin
        push     = '0;
        nonempty = '0;
        for (int p = 0; p < NPORTS; p++) begin
            push[p]     = reset && (sw_valid[p] === 1'b1);
            nonempty[p] = (count[p] != '0);
        end
    end

    // Round-robin search starting one past the last granted port. The cast
    // of the offset to two bits makes the modulo-4 wrap implicit, so the
    // last candidate examined is last_grant itself.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            cand = last_grant + 2'(i);
            if (!grant_found && nonempty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The output register can take a new word when it is empty, or when the
    // held word is being consumed this cycle.
    always_comb begin
        load   = grant_found && ((state == ST_EMPTY) || pkt_ready);
        pop    = '0;
        accept = '0;
        drop   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            pop[p]    = load && (grant_idx == 2'(p));
            // A full FIFO still accepts a push when it is popped on the
            // same edge: the freed slot is reused immediately.
            accept[p] = push[p] && ((count[p] != FULL_CNT) || pop[p]);
            drop[p]   = push[p] && !accept[p];
        end
    end

    assign head = mem[grant_idx][rd_ptr[grant_idx]];

    for (genvar g = 0; g < NPORTS; g++) begin : g_out
        assign fifo_full[g]          = (count[g] == FULL_CNT);
        assign drop_count[g*8 +: 8]  = drop_cnt[g];
    end

    // FIFO storage needs no reset: occupancy is tracked by count, and
    // accept is already forced low while reset is asserted.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (accept[p]) begin
                mem[p][wr_ptr[p]] <= {sw_addr[p*8 +: 8], sw_data[p*8 +: 8]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                wr_ptr[p]   <= '0;
                rd_ptr[p]   <= '0;
                count[p]    <= '0;
                drop_cnt[p] <= '0;
            end
            state      <= ST_EMPTY;
            last_grant <= 2'd3;
            pkt_valid  <= 1'b0;
            pkt_data   <= '0;
            pkt_addr   <= '0;
            pkt_port   <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                // DEPTH is a power of two, so pointers wrap by overflow.
                if (accept[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + AW'(1);
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + AW'(1);
                end
                case ({accept[p], pop[p]})
                    2'b10:   count[p] <= count[p] + CW'(1);
                    2'b01:   count[p] <= count[p] - CW'(1);
                    default: count[p] <= count[p];
                endcase
                if (drop[p] && (drop_cnt[p] != 8'hFF)) begin
                    drop_cnt[p] <= drop_cnt[p] + 8'd1;
                end
            end

            case (state)
                ST_EMPTY: begin
                    if (load) begin
                        state      <= ST_HOLD;
                        pkt_valid  <= 1'b1;
                        pkt_addr   <= head[15:8];
                        pkt_data   <= head[7:0];
                        pkt_port   <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                ST_HOLD: begin
                    if (pkt_ready) begin
                        if (load) begin
                            // Back-to-back: replace the consumed word.
                            pkt_addr   <= head[15:8];
                            pkt_data   <= head[7:0];
                            pkt_port   <= grant_idx;
                            last_grant <= grant_idx;
                        end else begin
                            state     <= ST_EMPTY;
                            pkt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    pkt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_egress_collector.sv
module tb_switch_egress_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sw_valid;
    logic [31:0] sw_data;
    logic [31:0] sw_addr;
    logic        pkt_ready;
    logic        pkt_valid;
    logic [7:0]  pkt_data;
    logic [7:0]  pkt_addr;
    logic [1:0]  pkt_port;
    logic [3:0]  fifo_full;
    logic [31:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected output words, {port, data}, in the order they must appear.
    logic [9:0] exp_q[$];

    switch_egress_collector #(.NPORTS(4), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_valid   (sw_valid),
        .sw_data    (sw_data),
        .sw_addr    (sw_addr),
        .pkt_ready  (pkt_ready),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_addr   (pkt_addr),
        .pkt_port   (pkt_port),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drivers: inputs change and outputs are sampled at the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sw_valid = '0;
        sw_data  = '0;
        sw_addr  = '0;
    endtask

    task automatic drive_port(input int p, input logic [7:0] d, input logic [7:0] a);
        sw_valid[p]      = 1'b1;
        sw_data[p*8 +: 8] = d;
        sw_addr[p*8 +: 8] = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        pkt_ready = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Consumes n words with pkt_ready held high; each must be valid on
    // consecutive cycles and match the head of exp_q.
    task automatic drain(input string tag, input int n);
        logic [9:0] exp_w;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, {31'd0, pkt_valid}, 32'd1);
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 32'd0, 32'd1);
            end else begin
                exp_w = exp_q.pop_front();
                check({tag, "_word"}, {22'd0, pkt_port, pkt_data}, {22'd0, exp_w});
            end
            tick();
        end
    endtask

    initial begin
        reset     = 1'b0;
        pkt_ready = 1'b0;
        idle_inputs();
        #1;
        // Reset state
        check("rst_valid", {31'd0, pkt_valid}, 32'd0);
        check("rst_full",  {28'd0, fifo_full}, 32'd0);
        check("rst_drops", drop_count, 32'd0);
        do_reset();

        // Single word on port 2, latency of two edges
        pkt_ready = 1'b1;
        drive_port(2, 8'hA5, 8'h01);
        tick();
        idle_inputs();
        check("single_not_early", {31'd0, pkt_valid}, 32'd0);
        tick();
        check("single_valid", {31'd0, pkt_valid}, 32'd1);
        check("single_data",  {24'd0, pkt_data}, 32'hA5);
        check("single_addr",  {24'd0, pkt_addr}, 32'h01);
        check("single_port",  {30'd0, pkt_port}, 32'd2);
        tick();
        check("single_done", {31'd0, pkt_valid}, 32'd0);

        // Round robin continues from last grant (2): port 3 before port 1
        drive_port(1, 8'h31, 8'h91);
        drive_port(3, 8'h33, 8'h93);
        tick();
        idle_inputs();
        tick();
        check("rr_first",  {22'd0, pkt_port, pkt_data}, {22'd0, 2'd3, 8'h33});
        tick();
        check("rr_second", {22'd0, pkt_port, pkt_data}, {22'd0, 2'd1, 8'h31});
        check("rr_addr",   {24'd0, pkt_addr}, 32'h91);
        tick();
        check("rr_done", {31'd0, pkt_valid}, 32'd0);

        // All four ports in one cycle, drained in port order 0..3
        do_reset();
        pkt_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            drive_port(p, 8'h10 + 8'(p), 8'h20 + 8'(p));
            exp_q.push_back({2'(p), 8'h10 + 8'(p)});
        end
        tick();
        idle_inputs();
        tick();
        drain("rr4", 4);
        check("rr4_done", {31'd0, pkt_valid}, 32'd0);

        // Backpressure and overflow on port 1
        do_reset();
        pkt_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            idle_inputs();
            drive_port(1, 8'(i), 8'h40 + 8'(i));
            tick();
        end
        idle_inputs();
        check("bp_valid", {31'd0, pkt_valid}, 32'd1);
        check("bp_data",  {24'd0, pkt_data}, 32'h01);
        check("bp_full",  {28'd0, fifo_full}, 32'h2);
        check("bp_drops", drop_count, 32'h0000_0200);
        tick();
        tick();
        check("bp_hold_data", {24'd0, pkt_data}, 32'h01);
        check("bp_hold_addr", {24'd0, pkt_addr}, 32'h41);
        check("bp_hold_port", {30'd0, pkt_port}, 32'd1);
        pkt_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back({2'd1, 8'(i)});
        end
        drain("bp", 5);
        check("bp_done",       {31'd0, pkt_valid}, 32'd0);
        check("bp_full_after", {28'd0, fifo_full}, 32'h0);

        // Full FIFO 0 with a simultaneous pop accepts the push
        do_reset();
        pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            drive_port(0, 8'h50 + 8'(i), 8'h00);
            tick();
        end
        idle_inputs();
        check("fp_full_before", {28'd0, fifo_full}, 32'h1);
        check("fp_head", {24'd0, pkt_data}, 32'h50);
        pkt_ready = 1'b1;
        drive_port(0, 8'h55, 8'h00);
        tick();
        idle_inputs();
        check("fp_full_kept", {28'd0, fifo_full}, 32'h1);
        check("fp_no_drop", drop_count, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back({2'd0, 8'h50 + 8'(i)});
        end
        drain("fp", 5);
        check("fp_done", {31'd0, pkt_valid}, 32'd0);

        // Drop counter saturation on port 3
        do_reset();
        pkt_ready = 1'b0;
        drive_port(3, 8'hEE, 8'hEF);
        for (int i = 1; i <= 305; i++) begin
            tick();
            if (i == 259) begin
                check("sat_254", drop_count, 32'hFE00_0000);
            end
        end
        idle_inputs();
        check("sat_ff", drop_count, 32'hFF00_0000);
        check("sat_full", {28'd0, fifo_full}, 32'h8);

        // Asynchronous reset while holding a word with 3 queued
        do_reset();
        pkt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            drive_port(0, 8'h60 + 8'(i), 8'h70 + 8'(i));
            tick();
        end
        idle_inputs();
        check("ar_pre_data", {24'd0, pkt_data}, 32'h60);
        #1 reset = 1'b0;
        #1;
        check("ar_valid", {31'd0, pkt_valid}, 32'd0);
        check("ar_word",  {14'd0, pkt_port, pkt_addr, pkt_data}, 32'd0);
        check("ar_full",  {28'd0, fifo_full}, 32'd0);
        check("ar_drops", drop_count, 32'd0);
        sw_valid = 4'hF;
        sw_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ar_quiet", {31'd0, pkt_valid}, 32'd0);
            tick();
        end
        drive_port(2, 8'h77, 8'h78);
        tick();
        idle_inputs();
        tick();
        check("ar_new_word", {22'd0, pkt_port, pkt_data}, {22'd0, 2'd2, 8'h77});
        tick();
        check("ar_new_done", {31'd0, pkt_valid}, 32'd0);

        // Report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
